// File: rtl/disp_scan_pkg.sv
// disp_scan_pkg: shared constants and helpers for the display scanner.
// This package holds the BCD digit width, the largest displayable code and
// the default geometry.
package disp_scan_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Largest code the downstream 7-segment converter can render.
  localparam int BCD_MAX = 9;

  // Default number of digits on the display.
  localparam int NDIG_DEF = 4;

  // Default number of clock cycles per digit slot.
  localparam int PRESC_DEF = 50000;

  // Returns 1 when the code is a displayable decimal digit (0..9).
  // Codes 10..15 return 0.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] code);
    return (code <= BCD_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/disp_scan_lz_mask.sv
// lz_mask: combinational leading-zero blank mask for the display scanner.
// This module is only built when LEADING_ZERO_BLANK_EN is defined.
// Bit i of the mask is set when digit i and every more-significant digit
// are all zero. Bit 0 is never set, so a value of zero still shows a
// single '0'.
`ifdef LEADING_ZERO_BLANK_EN
module lz_mask
  import disp_scan_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic [BCD_W*NDIG-1:0] snap,
  output logic [NDIG-1:0]       mask
);

  logic all_zero;

  // Walk from the most significant digit down and keep a running all-zero flag.
  always_comb begin
    all_zero = 1'b1;
    mask     = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      all_zero = all_zero && (snap[BCD_W*i +: BCD_W] == '0);
      mask[i]  = all_zero;
    end
  end

endmodule
`endif

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed scanner for an NDIG-digit 7-segment display.
//
// Each cycle this module presents one BCD digit (x), a converter enable (en),
// a one-hot digit select (an) and the selected digit's decimal point (dp).
// All outputs are registered.
//
// Input digits are snapshotted once per full scan, at the wrap from the last
// digit to digit 0. This keeps a digit from changing in the middle of a
// refresh.
//
// Outputs are computed from the post-update index and snapshot. Because of
// this, a freshly loaded snapshot is visible in the same output cycle that
// selects digit 0.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits. For a blanked digit en is forced low, but its an bit stays set.
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int PRESC = PRESC_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  e,
  input  logic [BCD_W*NDIG-1:0] d,
  input  logic [NDIG-1:0]       dp_in,
  output logic [BCD_W-1:0]      x,
  output logic                  en,
  output logic [NDIG-1:0]       an,
  output logic                  dp
);

  // A prescaler of 1 still needs a one-bit counter that always reads zero.
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW = $clog2(NDIG);

  localparam logic [PW-1:0]   PCNT_LAST = PW'(PRESC - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] SEL_ZERO  = NDIG'(1);

  // Scan control state.
  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic          primed;

  // Frozen copy of the inputs for the current scan.
  logic [BCD_W*NDIG-1:0] snap_d;
  logic [NDIG-1:0]       snap_dp;

  // Next-state values, also used to build the registered outputs.
  logic                  tick;
  logic                  idx_last;
  logic                  load;
  logic [PW-1:0]         pcnt_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [BCD_W*NDIG-1:0] snap_d_nxt;
  logic [NDIG-1:0]       snap_dp_nxt;

  // Selected digit and output candidates.
  logic [BCD_W-1:0] dig_sel;
  logic             dp_sel;
  logic             blanked;
  logic [NDIG-1:0]  an_nxt;
  logic             en_nxt;
  logic             dp_nxt;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] blank_mask;

  lz_mask #(
    .NDIG (NDIG)
  ) u_lz_mask (
    .snap (snap_d_nxt),
    .mask (blank_mask)
  );
`endif

  // Prescaler wrap, index advance and snapshot-load decision.
  always_comb begin
    tick     = (pcnt == PCNT_LAST);
    idx_last = (idx == IDX_LAST);
    pcnt_nxt = tick ? '0 : pcnt + PW'(1);
    idx_nxt  = idx;
    if (tick) begin
      idx_nxt = idx_last ? '0 : idx + IW'(1);
    end
    // Load at the wrap into digit 0. Before the first load after reset
    // (primed low), also load, so the first scan shows the current d.
    load        = (tick && idx_last) || !primed;
    snap_d_nxt  = load ? d     : snap_d;
    snap_dp_nxt = load ? dp_in : snap_dp;
  end

  // Digit selection and output formatting from the post-update state.
  always_comb begin
    dig_sel = snap_d_nxt[BCD_W*idx_nxt +: BCD_W];
    dp_sel  = snap_dp_nxt[idx_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    blanked = blank_mask[idx_nxt];
`else
    blanked = 1'b0;
`endif
    an_nxt = e ? (SEL_ZERO << idx_nxt) : '0;
    en_nxt = e && bcd_valid(dig_sel) && !blanked;
    dp_nxt = e && dp_sel;
  end

  // Prescaler, digit index and primed flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt   <= '0;
      idx    <= '0;
      primed <= 1'b0;
    end else begin
      pcnt   <= pcnt_nxt;
      idx    <= idx_nxt;
      primed <= 1'b1;
    end
  end

  // Snapshot registers; these only change at a scan wrap or on the priming load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_d  <= '0;
      snap_dp <= '0;
    end else begin
      snap_d  <= snap_d_nxt;
      snap_dp <= snap_dp_nxt;
    end
  end

  // Registered outputs to the converter and the digit drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x  <= '0;
      en <= 1'b0;
      an <= '0;
      dp <= 1'b0;
    end else begin
      // x is passed through even when en is low, so the converter input is stable.
      x  <= dig_sel;
      en <= en_nxt;
      an <= an_nxt;
      dp <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: scoreboard bench for disp_scan (NDIG=4, PRESC=3).
module tb_disp_scan;

  localparam int NDIG  = 4;
  localparam int PRESC = 3;
  localparam int OW    = 4 + 1 + NDIG + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        e = 1'b0;
  logic [15:0] d = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  x;
  logic        en;
  logic [3:0]  an;
  logic        dp;

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] exp_q[$];

  int          m_pcnt;
  int          m_idx;
  int          m_primed;
  logic [15:0] m_snap;
  logic [3:0]  m_sdp;

  disp_scan #(
    .NDIG  (NDIG),
    .PRESC (PRESC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .e       (e),
    .d       (d),
    .dp_in   (dp_in),
    .x       (x),
    .en      (en),
    .an      (an),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_pcnt   = 0;
    m_idx    = 0;
    m_primed = 0;
    m_snap   = '0;
    m_sdp    = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"},  32'(x),  0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_an"}, 32'(an), 0);
    chk({tag, "_dp"}, 32'(dp), 0);
  endtask

  // Advance the reference model by one clock, push its prediction,
  // clock the DUT, then pop the prediction and compare it with the DUT.
  task automatic cycle();
    bit            tick;
    bit            last;
    bit            load;
    bit            blank;
    logic [3:0]    dig;
    logic [OW-1:0] p;
    logic [OW-1:0] q;
    tick = (m_pcnt == PRESC - 1);
    last = (m_idx == NDIG - 1);
    load = (tick && last) || (m_primed == 0);
    m_pcnt = tick ? 0 : m_pcnt + 1;
    if (tick) m_idx = last ? 0 : m_idx + 1;
    if (load) begin
      m_snap = d;
      m_sdp  = dp_in;
    end
    m_primed = 1;
    dig = 4'((m_snap >> (4 * m_idx)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    blank = (m_idx > 0) && ((m_snap >> (4 * m_idx)) == 16'h0);
`else
    blank = 1'b0;
`endif
    p[9:6] = dig;
    p[5]   = e && (dig <= 4'd9) && !blank;
    p[4:1] = e ? (4'b0001 << m_idx) : 4'b0000;
    p[0]   = e && m_sdp[m_idx];
    exp_q.push_back(p);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'(exp_q.size()), 1);
    end else begin
      q = exp_q.pop_front();
      chk("x",  32'(x),  32'(q[9:6]));
      chk("en", 32'(en), 32'(q[5]));
      chk("an", 32'(an), 32'(q[4:1]));
      chk("dp", 32'(dp), 32'(q[0]));
    end
  endtask

  initial begin
    int hits;
    int guard;
    model_reset();
    e     = 1'b1;
    d     = 16'h1234;
    dp_in = 4'b0100;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // First output after release: digit 0 of the live d.
    cycle();
    chk("first_x",  32'(x),  4);
    chk("first_an", 32'(an), 1);
    repeat (13) cycle();

    // Change d partway through a scan.
    guard = 0;
    while (m_idx != 1 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("reach_idx1", 32'(m_idx), 1);
    d = 16'h5678;
    repeat (16) cycle();

    // Blank the display, then resume without restarting the scan.
    e = 1'b0;
    repeat (10) cycle();
    e = 1'b1;
    repeat (8) cycle();

    // Non-decimal code in digit 1.
    d     = 16'h00A5;
    dp_in = 4'b0001;
    hits  = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (an == 4'b0010 && m_snap == 16'h00A5) begin
        chk("a5_x1",  32'(x),  4'hA);
        chk("a5_en1", 32'(en), 0);
        hits++;
      end
      if (an == 4'b0001 && m_snap == 16'h00A5) begin
        chk("a5_x0",  32'(x),  5);
        chk("a5_en0", 32'(en), 1);
        hits++;
      end
    end
    chk("a5_hits", 32'(hits > 0), 1);

    // Leading-zero cases (blanked only when the option is built in).
    d = 16'h0007;
    repeat (14) cycle();
    d = 16'h0000;
    repeat (14) cycle();

    // Asynchronous reset in the middle of the digit-2 slot.
    d     = 16'h9876;
    dp_in = 4'b1010;
    guard = 0;
    while (!(m_idx == 2 && m_pcnt == 1) && guard < 40) begin
      cycle();
      guard++;
    end
    chk("reach_idx2", 32'(m_idx), 2);
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();
    chk("rst_x",  32'(x),  6);
    chk("rst_an", 32'(an), 1);
    repeat (12) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
